// File: rtl/multu_hilo_unit.sv
// Unsigned multiply into HI/LO: radix-2 shift-add over WIDTH cycles,
// product held until HILO_WR commits it; MFHI/MFLO read back.
module multu_hilo_unit #(
  parameter int          WIDTH   = 32,
  parameter logic [5:0]  HILO_WR = 6'b111111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam int         CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   step;

  // One shift-add step: conditional add into the upper half, keep carry, shift right
  always_comb begin
    sum  = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (product[0])
      sum = sum + {1'b0, mcand};
    step = {sum, product[WIDTH-1:1]};
  end

  // Sequencer, datapath registers and HI/LO commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      product <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (signal == MULTU) begin
            mcand   <= dataA;
            product <= {{WIDTH{1'b0}}, dataB};
            count   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          product <= step;
          if (count == LAST)
            state <= DONE;
          else
            count <= count + 1'b1;
        end
        DONE: begin
          if (signal == MULTU) begin
            mcand   <= dataA;
            product <= {{WIDTH{1'b0}}, dataB};
            count   <= '0;
            state   <= RUN;
          end else if (signal == HILO_WR) begin
            hi    <= product[2*WIDTH-1:WIDTH];
            lo    <= product[WIDTH-1:0];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags decoded straight from the state register
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Move-from-HI/LO read port; only committed values are visible
  always_comb begin
    dataOut = '0;
    if (signal == MFHI)
      dataOut = hi;
    else if (signal == MFLO)
      dataOut = lo;
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Bench for multu_hilo_unit: table vectors plus corner sequences,
// expected products queued at launch and checked at commit.
module tb_multu_hilo_unit;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] WR    = 6'b111111;
  localparam logic [5:0] OTHER = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  signal;
  logic [31:0] dataA, dataB;
  logic [31:0] hi, lo, dataOut;
  logic        busy, done;

  int nvec = 0;
  int nerr = 0;
  logic [63:0] sb[$];
  logic [63:0] cur = '0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
  } vec_t;

  vec_t tbl[7];

  multu_hilo_unit #(.WIDTH(32), .HILO_WR(6'b111111)) dut (
    .clk(clk), .rst_n(rst_n), .signal(signal),
    .dataA(dataA), .dataB(dataB),
    .hi(hi), .lo(lo), .dataOut(dataOut),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signal = MULTU;
    dataA  = a;
    dataB  = b;
    sb.push_back(64'(a) * 64'(b));
    @(posedge clk);
    #1;
    chk("busy_after_load", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int inj, input logic [63:0] hold);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      dataA = $urandom;
      dataB = $urandom;
      signal = (n == inj) ? WR : MULTU;
      @(posedge clk);
      n++;
      #1;
      if (n == inj + 1) begin
        chk("inject_busy", 64'(busy), 64'd1);
        chk("inject_hilo", {hi, lo}, hold);
      end
    end
    chk("latency", 64'(n), 64'd32);
    chk("hold_at_done", {hi, lo}, hold);
  endtask

  task automatic commit();
    logic [63:0] e;
    @(negedge clk);
    signal = WR;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL scoreboard: got empty expected entry");
      return;
    end
    e = sb.pop_front();
    chk("commit_hilo", {hi, lo}, e);
    chk("commit_idle", {62'd0, busy, done}, 64'd0);
    signal = MFHI;
    #1;
    chk("mfhi", 64'(dataOut), 64'(e[63:32]));
    signal = MFLO;
    #1;
    chk("mflo", 64'(dataOut), 64'(e[31:0]));
    signal = OTHER;
    cur = e;
  endtask

  initial begin
    tbl[0] = '{32'd3, 32'd5, 32'd0, 32'd15};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    tbl[2] = '{32'd0, 32'hDEADBEEF, 32'd0, 32'd0};
    tbl[3] = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    tbl[4] = '{32'h80000000, 32'd2, 32'd1, 32'd0};
    tbl[5] = '{32'h00010000, 32'h00010000, 32'd1, 32'd0};
    tbl[6] = '{32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE};

    rst_n  = 1'b0;
    signal = OTHER;
    dataA  = '0;
    dataB  = '0;
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", {62'd0, busy, done}, 64'd0);
    chk("rst_dataout", 64'(dataOut), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start(tbl[i].a, tbl[i].b);
      wait_done(-1, cur);
      commit();
      chk("tbl_hilo", {hi, lo}, {tbl[i].h, tbl[i].l});
    end

    for (int i = 0; i < 3; i++) begin
      start($urandom, $urandom);
      wait_done(-1, cur);
      commit();
    end

    // HILO_WR in IDLE has no effect
    @(negedge clk);
    signal = WR;
    @(posedge clk);
    #1;
    chk("idle_wr_hilo", {hi, lo}, cur);
    chk("idle_wr_busy", 64'(busy), 64'd0);

    // HILO_WR injected mid-run is ignored
    start(32'd1000, 32'd777);
    wait_done(10, cur);
    commit();
    chk("inject_result", 64'(lo), 64'd777000);

    // Reset mid-run
    start(32'd7, 32'd9);
    repeat (16) begin
      @(negedge clk);
      signal = MULTU;
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    void'(sb.pop_back());
    cur = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    signal = OTHER;
    start(32'd7, 32'd9);
    wait_done(-1, cur);
    commit();
    chk("postrst_lo", 64'(lo), 64'd63);

    // Restart from DONE discards pending product
    start(32'd2, 32'd3);
    wait_done(-1, cur);
    commit();
    start(32'd7, 32'd7);
    wait_done(-1, cur);
    void'(sb.pop_front());
    start(32'd4, 32'd5);
    chk("restart_hold", {hi, lo}, 64'd6);
    wait_done(-1, 64'd6);
    commit();
    chk("restart_lo", 64'(lo), 64'd20);

    // Read port decode with hi=1, lo=2
    start(32'd2, 32'h80000001);
    wait_done(-1, cur);
    commit();
    signal = OTHER;
    #1;
    chk("rd_other", 64'(dataOut), 64'd0);
    signal = MFHI;
    #1;
    chk("rd_mfhi", 64'(dataOut), 64'd1);
    signal = MFLO;
    #1;
    chk("rd_mflo", 64'(dataOut), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
